// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//   Handles load-use hazards the forwarding path cannot cover, dcache waits,
//   taken-branch/jump redirects from EX and halt. Drives the per-latch
//   enable/flush strobes and pc_en.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     defined   -> stall_cnt / flush_cnt are saturating performance counters
//     undefined -> stall_cnt / flush_cnt are tied to 0 (no counter flops)
//
// Parameters
//   DWAIT_MAX  dcache wait cycles before timeout_err is raised (>=1)
//   CNT_W      performance counter width
//
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   ifid_rs/rt/i_type        source fields of the instruction in IF/ID
//   idex_MemRead/idex_wsel   load flag and destination of the instruction in ID/EX
//   ex_redirect              taken branch/jump resolved in EX
//   exmem_dREN/dWEN/halt     data request and halt flag in EX/MEM
//   ihit, dhit               cache hit strobes
//   pc_en, *_en, *_flush     PC/latch control (combinational from state+inputs)
//   halt_o                   core halted
//   timeout_err              sticky dcache wait timeout
//   stall_cnt, flush_cnt     performance counters
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int unsigned DWAIT_MAX = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_i_type,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_wsel,
    input  logic             ex_redirect,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt_o,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(DWAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DWAIT  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Winning rule of the priority chain for the current cycle.
    typedef enum logic [2:0] {
        ACT_RESET    = 3'd0,
        ACT_HALTED   = 3'd1,
        ACT_HALT     = 3'd2,
        ACT_DWAIT    = 3'd3,
        ACT_REDIRECT = 3'd4,
        ACT_LOADUSE  = 3'd5,
        ACT_IMISS    = 3'd6,
        ACT_RUN      = 3'd7
    } act_t;

    state_t            state;
    state_t            state_next;
    act_t              act;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              dpend;
    logic              loaduse;

    // Hazard detection terms.
    always_comb begin
        dpend   = (exmem_dREN | exmem_dWEN) & ~dhit;
        loaduse = idex_MemRead & (idex_wsel != 5'd0) &
                  ((idex_wsel == ifid_rs) |
                   (~ifid_i_type & (idex_wsel == ifid_rt)));
    end

    // Priority arbitration; a pending dcache access outranks a halt in EX/MEM.
    always_comb begin
        act = ACT_RUN;
        if (RST) begin
            act = ACT_RESET;
        end else if (state == ST_HALTED) begin
            act = ACT_HALTED;
        end else if (exmem_halt && !dpend) begin
            act = ACT_HALT;
        end else if (dpend) begin
            act = ACT_DWAIT;
        end else if (ex_redirect) begin
            act = ACT_REDIRECT;
        end else if (loaduse) begin
            act = ACT_LOADUSE;
        end else if (!ihit) begin
            act = ACT_IMISS;
        end
    end

    // Control outputs and next state. Every flush is paired with its enable.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halt_o      = 1'b0;
        state_next  = ST_RUN;
        case (act)
            ACT_RESET: begin
                state_next = ST_RUN;
            end
            ACT_HALTED: begin
                halt_o     = 1'b1;
                state_next = ST_HALTED;
            end
            ACT_HALT: begin
                state_next = ST_HALTED;
            end
            ACT_DWAIT: begin
                state_next = ST_DWAIT;
            end
            ACT_REDIRECT: begin
                // Also discards a fetch abandoned on an icache miss.
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            ACT_LOADUSE: begin
                // Hold PC and IF/ID, insert one bubble into ID/EX.
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end
            ACT_IMISS: begin
                // Hold PC, feed a NOP into IF/ID while downstream drains.
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end
            default: begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        endcase
    end

    // Saturating increment of the dcache wait counter.
    always_comb begin
        if (wait_cnt >= WAIT_W'(DWAIT_MAX)) begin
            wait_inc = wait_cnt;
        end else begin
            wait_inc = wait_cnt + WAIT_W'(1);
        end
    end

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (act == ACT_DWAIT) begin
                wait_cnt <= wait_inc;
                if (wait_inc == WAIT_W'(DWAIT_MAX)) begin
                    timeout_err <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             stall_hit;
    logic             flush_hit;

    // A halted core is idle, not stalled.
    always_comb begin
        stall_hit = ~pc_en & (act != ACT_HALTED) & (act != ACT_RESET);
        flush_hit = (act == ACT_REDIRECT);
    end

    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_hit && !(&stall_q)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_hit && !(&flush_q)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
